// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one registered bitwise logic unit among four requesters.
// Define LOGIC_ARB_ERR_EN to flag opcodes 5-7 via rsp_err (otherwise they decode as XOR).
module logic_unit_arbiter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [11:0]    req_op,
  input  logic [4*W-1:0] req_a,
  input  logic [4*W-1:0] req_b,
  output logic [3:0]     req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic [15:0]    op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [1:0] last, win;
  logic [2:0] op;
  logic [W-1:0] a, b, res;
  logic bad;
  logic grant;
  // Scan downward so the requester closest after last wins.
  always_comb begin
    win = last;
    for (int i = 3; i >= 0; i--) if (req_valid[last + 2'(i) + 2'd1]) win = last + 2'(i) + 2'd1;
  end
  assign grant = state == IDLE && |req_valid;
  always_comb begin
    state_nxt = state == IDLE ? (grant ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready = grant ? 4'b0001 << win : 4'b0000;
  end
  assign rsp_valid = state == RESP;
`ifdef LOGIC_ARB_ERR_EN
  assign bad = op > 3'd4;
`else
  assign bad = 1'b0;
`endif
  assign res = bad ? '0 : op == 3'd0 ? ~(a & b) : op == 3'd1 ? ~a : op == 3'd2 ? a & b : op == 3'd3 ? a | b : a ^ b;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd3;
      rsp_id <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rsp_id <= win;
        op <= req_op[3*win +: 3];
        a <= req_a[W*win +: W];
        b <= req_b[W*win +: W];
      end
      if (state == EXEC) begin
        rsp_data <= res;
        rsp_err <= bad;
      end
      if (state == RESP && rsp_ready) begin
        last <= rsp_id;
        op_count <= op_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized scoreboard bench for logic_unit_arbiter with a spec-level reference model.
module tb_logic_unit_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] op_count;
  int n_chk = 0, n_fail = 0;

  logic_unit_arbiter #(.W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] id; logic [15:0] data; logic err;} exp_t;
  exp_t q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      3'd0: return {1'b0, ~(a & b)};
      3'd1: return {1'b0, ~a};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
`ifdef LOGIC_ARB_ERR_EN
      default: return {1'b1, 16'h0000};
`else
      default: return {1'b0, a ^ b};
`endif
    endcase
  endfunction

  // Model: one op in flight; response appears two cycles after the grant cycle.
  int busy = 0, age = 0, last = 3, w;
  logic [15:0] cnt = '0;
  logic cnt_load = 1'b0;
  logic [3:0] exp_rdy;
  always @(negedge clk) begin
    if (rst) begin
      busy = 0; age = 0; last = 3; cnt = '0; q.delete();
    end else begin
      if (cnt_load) cnt = 16'hFFFF;
      if (busy != 0) age++;
      exp_rdy = '0;
      w = -1;
      if (busy == 0)
        for (int k = 1; k <= 4; k++)
          if (w < 0 && req_valid[(last + k) % 4]) w = (last + k) % 4;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(busy != 0 && age >= 2));
      chk("op_count", 32'(op_count), 32'(cnt));
      if (busy != 0 && age >= 2) begin
        if (q.size() == 0) chk("queue_empty", 32'(0), 32'(1));
        else begin
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
          chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
          if (rsp_ready) begin
            last = int'(q[0].id);
            void'(q.pop_front());
            cnt = cnt + 16'd1;
            busy = 0;
          end
        end
      end else if (w >= 0) begin
        exp_t e;
        logic [16:0] r;
        r = model(req_op[3*w +: 3], req_a[16*w +: 16], req_b[16*w +: 16]);
        e.id = 2'(w); e.data = r[15:0]; e.err = r[16];
        q.push_back(e);
        busy = 1; age = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(int i, logic [2:0] op, logic [15:0] a, logic [15:0] b);
    req_op[3*i +: 3] = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #3;
    do_reset();
    // Requester 0 AND
    step();
    put(0, 3'd2, 16'hF0F0, 16'hFF00);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1 chk("t1_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    #1;
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_data", 32'(rsp_data), 32'hF000);
    chk("t1_id", 32'(rsp_id), 32'h0);
    step();
    #1 chk("t1_count", 32'(op_count), 32'h1);
    // Fairness with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) put(i, 3'd0, 16'hFFFF, 16'h00FF);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (16) step();
    req_valid = '0;
    repeat (4) step();
    // Held response
    put(2, 3'd1, 16'h1234, 16'($urandom));
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    put(2, 3'd3, 16'h0000, 16'h0000);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_data", 32'(rsp_data), 32'hEDCB);
      chk("hold_ready", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    #1 chk("hold_release", 32'(rsp_valid), 32'h0);
    // Illegal opcode
    step();
    put(1, 3'd6, 16'hA5C3, 16'h0FF0);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    #1;
`ifdef LOGIC_ARB_ERR_EN
    chk("illegal_data", 32'(rsp_data), 32'h0);
    chk("illegal_err", 32'(rsp_err), 32'h1);
`else
    chk("illegal_data", 32'(rsp_data), 32'hAA33);
    chk("illegal_err", 32'(rsp_err), 32'h0);
`endif
    step();
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) != 0) put(i, 3'($urandom), 16'($urandom), 16'($urandom));
      req_valid = 4'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
    // Counter wrap
    force dut.op_count = 16'hFFFF;
    cnt_load = 1'b1;
    step();
    release dut.op_count;
    step();
    cnt_load = 1'b0;
    put(3, 3'd4, 16'h1111, 16'h2222);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    repeat (3) step();
    #1 chk("wrap", 32'(op_count), 32'h0);
    // Reset during EXEC
    step();
    put(2, 3'd2, 16'hFFFF, 16'h1234);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_op_count", 32'(op_count), 32'h0);
    chk("mid_rsp_data", 32'(rsp_data), 32'h0);
    chk("mid_rsp_id", 32'(rsp_id), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) put(i, 3'd3, 16'($urandom), 16'($urandom));
    req_valid = 4'hF;
    #1 chk("mid_next_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (5) step();
    chk("drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (Nand, Not, And, Or, Xor) among four requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one requester at a time, executes the operation and returns the tagged result on a single response channel. It sits between the gate-level logic primitives and the client blocks that need them.

## Interface
Parameters:
- `W`, 16, operand/result width in bits

Ports:
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req_valid`  input  4  per-requester request valid; bit i = requester i
- `req_op`  input  12  3-bit opcode per requester; requester i at [3i+2:3i]
- `req_a`  input  4*W  operand A per requester; requester i at [W*i+W-1:W*i]
- `req_b`  input  4*W  operand B per requester, same packing
- `req_ready`  output  4  one-hot accept strobe; at most one bit high
- `rsp_valid`  output  1  result available
- `rsp_ready`  input  1  consumer accepts result
- `rsp_id`  output  2  index of the requester that owns the result
- `rsp_data`  output  W  result
- `rsp_err`  output  1  illegal opcode flag (see Configuration)
- `op_count`  output  16  count of completed responses

## Operation
- Opcodes: 0 NAND ~(a&b); 1 NOT ~a (b ignored); 2 AND; 3 OR; 4 XOR; 5–7 illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid` bit is set, pick the winner round-robin, starting at `(last+1) mod 4` and searching upward with wrap. Assert `req_ready[winner]` combinationally in the same cycle. The handshake completes on that edge: latch op, a, b and id, then go to EXEC. If no request is valid, stay in IDLE with `req_ready`=0.
- EXEC: compute the result from the latched operands and register it into `rsp_data`/`rsp_err`, then go to RESP. `req_ready`=0.
- RESP: `rsp_valid`=1. Hold `rsp_id`, `rsp_data` and `rsp_err` stable. When `rsp_ready`=1, set `last` ← id, increment `op_count` (mod 2^16, wraps 0xFFFF→0) and return to IDLE.
- Requests are not accepted in EXEC or RESP, so only one operation is in flight.
- A requester that drops `req_valid` before a grant loses nothing; its operands are never sampled.
- Input changes after acceptance do not affect the in-flight result.

## Timing
- Reset values (async, immediate): state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `op_count`=0, `last`=3, so requester 0 has first priority after reset.
- Latency: handshake at edge T, `rsp_valid` rises after edge T+1 (visible in cycle T+2). With `rsp_ready` held high, the next grant is possible in cycle T+3. Peak throughput is one operation per 3 cycles.
- `rsp_ready` sampled in IDLE or EXEC is ignored.
- Fairness: with all four requesters continuously valid, the grant order is 0,1,2,3,0,…
- Reset asserted mid-operation aborts it. The in-flight result is discarded, no response is produced, and `op_count` is not incremented.

## Configuration
- `LOGIC_ARB_ERR_EN` defined: opcodes 5–7 produce `rsp_data`=0 and `rsp_err`=1. The response is still delivered and counted.
- `LOGIC_ARB_ERR_EN` undefined: `rsp_err` is tied to 0. Opcodes 5–7 decode as XOR.

## Test plan
- Reset, then requester 0 sends op=2, a=16'hF0F0, b=16'hFF00. Expected: `req_ready`=4'b0001 in the request cycle; `rsp_valid` two cycles later with `rsp_data`=16'hF000, `rsp_id`=0, `op_count`=1 after accept.
- All four requesters held valid, each with op=0, a=16'hFFFF, b=16'h00FF, and `rsp_ready`=1. Expected: `rsp_id` sequence 0,1,2,3,0; each `rsp_data`=16'hFF00; responses 3 cycles apart.
- Requester 2 sends op=1, a=16'h1234, `rsp_ready`=0 for 5 cycles. Expected: `rsp_data`=16'hEDCB held stable with `rsp_valid`=1 and `req_ready`=0 throughout; returns to IDLE one cycle after `rsp_ready`=1.
- Requester 1 sends op=6. Expected: with `LOGIC_ARB_ERR_EN` defined, `rsp_err`=1 and `rsp_data`=0. Without the macro, `rsp_err`=0 and `rsp_data`=a^b.
- Assert `rst` during EXEC of a grant. Expected: all outputs at reset values immediately; no `rsp_valid`; `op_count`=0; the next grant goes to requester 0.
- Preload 65535 completions (or force the counter), then complete one more. Expected: `op_count` wraps to 0.
